// File: rtl/load_store_unit_if.sv
// Request/response handshake plus doubleword memory port of the load/store unit.
// master = execute-stage requester, slave = load_store_unit, mem = data memory.
interface load_store_unit_if #(
    parameter int BITS   = 64,
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [BITS-1:0]   req_addr;
    logic [BITS-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [BITS-1:0]   resp_rdata;
    logic [ADDR_W-1:0] mem_endr;
    logic              mem_we;
    logic [BITS-1:0]   mem_din;
    logic [BITS-1:0]   mem_dout;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_err, resp_rdata, mem_endr, mem_we, mem_din
    );

    modport mem (
        input  mem_endr, mem_we, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store unit in front of a 64-bit doubleword memory.
// Sub-doubleword stores are a single-cycle read-modify-write on the combinational read port.
module load_store_unit #(
    parameter int BITS   = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);
    localparam int NB = BITS / 8;
    localparam int SH_W = $clog2(BITS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [2:0]        off_q;
    logic [ADDR_W-1:0] endr_q;
    logic [BITS-1:0]   wdata_q;
    logic [BITS-1:0]   rdata_q;
    logic              err_q;

    logic              req_bad;
    logic [BITS-1:0]   lane;
    logic [BITS-1:0]   load_val;
    logic [BITS-1:0]   merged;

    function automatic logic req_is_bad(input logic we, input logic [2:0] f3,
                                        input logic [BITS-1:0] a);
        logic bad_op;
        logic misal;
        logic oob;
        bad_op = we ? f3[2] : (f3 == 3'b111);
        case (f3[1:0])
            2'b01:   misal = a[0];
            2'b10:   misal = |a[1:0];
            2'b11:   misal = |a[2:0];
            default: misal = 1'b0;
        endcase
        oob = (a >> 3) >= BITS'(DEPTH);
        return bad_op | misal | oob;
    endfunction

    function automatic logic [BITS-1:0] load_extend(input logic [BITS-1:0] ln,
                                                    input logic [2:0] f3);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        b = ln[7:0];
        h = ln[15:0];
        w = ln[31:0];
        case (f3)
            3'b000:  return BITS'(b);
            3'b001:  return BITS'(h);
            3'b010:  return BITS'(w);
            3'b011:  return ln;
            3'b100:  return BITS'(ln[7:0]);
            3'b101:  return BITS'(ln[15:0]);
            3'b110:  return BITS'(ln[31:0]);
            default: return '0;
        endcase
    endfunction

    function automatic logic [BITS-1:0] store_merge(input logic [BITS-1:0] old,
                                                    input logic [BITS-1:0] wd,
                                                    input logic [2:0] f3,
                                                    input logic [2:0] off);
        logic [NB-1:0]   bmask;
        logic [BITS-1:0] bitmask;
        logic [BITS-1:0] wsh;
        case (f3[1:0])
            2'b00:   bmask = NB'(1);
            2'b01:   bmask = NB'(3);
            2'b10:   bmask = NB'(15);
            default: bmask = '1;
        endcase
        bmask = bmask << off;
        wsh   = wd << {off, 3'b000};
        for (int i = 0; i < NB; i++) begin
            bitmask[i*8 +: 8] = {8{bmask[i]}};
        end
        return (old & ~bitmask) | (wsh & bitmask);
    endfunction

    always_comb begin
        req_bad  = req_is_bad(bus.req_we, bus.req_funct3, bus.req_addr);
        lane     = bus.mem_dout >> SH_W'({off_q, 3'b000});
        load_val = load_extend(lane, f3_q);
        merged   = store_merge(bus.mem_dout, wdata_q, f3_q, off_q);
    end

    // endr_q is loaded only for requests that will reach ACCESS, so the memory
    // index changes exactly on entry to ACCESS and holds afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            endr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        off_q   <= bus.req_addr[2:0];
                        wdata_q <= bus.req_wdata;
                        if (req_bad) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state_q <= RESP;
                        end else begin
                            endr_q  <= bus.req_addr[ADDR_W+2:3];
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    err_q   <= 1'b0;
                    rdata_q <= we_q ? '0 : load_val;
                    state_q <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // mem_we is a pure state decode so the asynchronous reset kills a pending write.
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_endr   = endr_q;
    assign bus.mem_we     = (state_q == ACCESS) && we_q;
    assign bus.mem_din    = bus.mem_we ? merged : '0;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the RISC-V datapath, sitting directly upstream of the 64-bit doubleword data memory. It accepts one byte-addressed load or store per request from the execute stage and translates it into doubleword accesses on the memory's `endr`/`We`/`din`/`dout` port. Sub-doubleword stores are done as a single-cycle read-modify-write, using the memory's combinational read. Loads return the selected byte, half, word or doubleword, sign- or zero-extended.

## Interface

Parameters:
- BITS, 64, data width; must equal the memory word width.
- ADDR_W, 5, doubleword index width; must equal the memory `endr` width.
- DEPTH, 32, number of doublewords; equals 2^ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- req_addr  in  BITS  byte address from the ALU.
- req_wdata  in  BITS  store data; the low 8/16/32/64 bits are used.
- resp_valid  out  1  one-cycle pulse marking completion.
- resp_err  out  1  valid with resp_valid; misaligned, out-of-range or unsupported request.
- resp_rdata  out  BITS  load result; 0 for stores and errors.
- mem_endr  out  ADDR_W  doubleword index to the memory.
- mem_we  out  1  memory write enable.
- mem_din  out  BITS  merged doubleword to write.
- mem_dout  in  BITS  combinational read data from the memory.

## Operation

States: IDLE, ACCESS, RESP.

**IDLE** (req_ready=1). On accept, latch we, funct3, addr and wdata, then check for an error. An error is any of:
- funct3 unsupported: load 111, or store ≥100.
- Misaligned: H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0.
- Out of range: addr[BITS-1:ADDR_W+3]≠0.

Error → RESP with err=1. Otherwise → ACCESS.

**ACCESS** (one cycle):
- mem_endr = latched addr[ADDR_W+2:3]. Lane offset = addr[2:0] bytes.
- Load: select the lane from mem_dout. Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU and LD. Register the result into resp_rdata.
- Store: mem_din = mem_dout with only the addressed 1/2/4/8 bytes replaced by the low bytes of wdata. mem_we=1 for this cycle only, so the memory writes on the closing edge.
- Always → RESP.

**RESP**: resp_valid=1 for exactly one cycle, then → IDLE. There is no response backpressure.

Other rules:
- mem_we is decoded from (state==ACCESS && latched we). It is never high in any other state.
- mem_endr holds its last value outside ACCESS.
- Reset at any time forces IDLE; in-flight requests are dropped with no response and no write. Because mem_we is decoded from state, the asynchronous reset deasserts it immediately.

## Timing

- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_endr=0, mem_din=0, all latches 0.
- Normal request: accepted at edge N; ACCESS during cycle N+1 (store committed at edge N+2); resp_valid high during cycle N+2; req_ready high again in cycle N+3.
- Error request: accepted at edge N; resp_valid+resp_err during cycle N+1; no ACCESS cycle, mem_we never asserted.
- Throughput: one request per 3 cycles (2 for errors). req_valid while req_ready=0 is ignored.
- resp_rdata and resp_err are held until the next response.

## Test plan

Memory is preloaded with word0=51, word2=94, word5=18.

1. LD addr 0x10 → resp_rdata=94, resp_err=0, resp_valid two cycles after accept, mem_we never 1.
2. SB wdata=0xFF at addr 0x01, then LD 0x00 → memory word0=0xFF33; LD returns 0xFF33 and the other bytes are unchanged.
3. After scenario 2:
   - LB 0x01 → 0xFFFF_FFFF_FFFF_FFFF.
   - LBU 0x01 → 0xFF.
   - LH 0x00 → 0xFFFF_FFFF_FFFF_FF33.
4. Error cases:
   - LW 0x2A → resp_err=1 one cycle after accept, resp_rdata=0.
   - SD 0x04 → resp_err=1, word0 unchanged.
   - LD 0x100 → resp_err=1.
   - Load funct3=111 → resp_err=1.
5. SW wdata=0x1234_5678 at 0x2C → word5=0x1234_5678_0000_0012; LWU 0x28 → 0x12.
6. Assert rst_n=0 during the ACCESS cycle of SD 0x10 → mem_we drops immediately, word2 stays 94, no resp_valid, req_ready=1 after release.
